// File: rtl/apb_reg_slave.sv
// APB completer holding a bank of byte-strobed word registers; the top register is a read-only ID.
// Optional wait-state insertion is compiled in with the APB_SLV_WAIT_EN macro.
module apb_reg_slave #(
    parameter int                    PADDR_SIZE  = 16,
    parameter int                    PDATA_SIZE  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter logic [PDATA_SIZE-1:0] ID_VALUE    = 'hA5B0_0001,
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic [PADDR_SIZE-1:0]          PADDR,
    input  logic                           PWRITE,
    input  logic [PDATA_SIZE/8-1:0]        PSTRB,
    input  logic [PDATA_SIZE-1:0]          PWDATA,
    output logic [PDATA_SIZE-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    output logic [NUM_REGS*PDATA_SIZE-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int BYTES = PDATA_SIZE / 8;
    localparam int AW    = $clog2(BYTES);
    localparam int IW    = $clog2(NUM_REGS);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state_reg, state_next;
    logic [IW-1:0]           idx_reg;
    logic                    write_reg;
    logic [BYTES-1:0]        strb_reg;
    logic [PDATA_SIZE-1:0]   wdata_reg;
    logic                    err_reg;
    logic [PDATA_SIZE-1:0]   prdata_reg;
    logic [NUM_REGS-1:0]     wr_pulse_reg, wr_pulse_next;
    logic [PDATA_SIZE-1:0]   regs_reg [NUM_REGS-1];
    logic [PDATA_SIZE-1:0]   view [NUM_REGS];

    logic [IW-1:0] idx_c;
    logic          err_c, setup_c, complete_c, commit_c, pready_c;

    // Address decode on the live bus; only meaningful during setup.
    assign idx_c   = PADDR[AW +: IW];
    assign err_c   = ((PADDR & PADDR_SIZE'(BYTES - 1)) != '0)
                   || ({1'b0, PADDR} >= (PADDR_SIZE + 1)'(NUM_REGS * BYTES))
                   || (PWRITE && (idx_c == IW'(NUM_REGS - 1)));

    assign setup_c    = (state_reg == IDLE) && PSEL && !PENABLE;
    assign complete_c = (state_reg == ACCESS) && PSEL && PENABLE && pready_c;
    assign commit_c   = complete_c && write_reg && !err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_view
            if (gi < NUM_REGS - 1) begin : g_rw
                assign view[gi] = regs_reg[gi];
            end else begin : g_id
                assign view[gi] = ID_VALUE;
            end
            assign reg_q[gi*PDATA_SIZE +: PDATA_SIZE] = view[gi];
        end
    endgenerate

`ifdef APB_SLV_WAIT_EN
    logic [3:0] cnt_reg, cnt_next;

    assign pready_c = (state_reg == IDLE) || (cnt_reg == 4'd0);

    always_comb begin
        cnt_next = cnt_reg;
        if (setup_c) begin
            cnt_next = 4'(WAIT_CYCLES);
        end else if (state_reg == ACCESS) begin
            if (!PSEL)
                cnt_next = 4'd0;
            else if (PENABLE && (cnt_reg != 4'd0))
                cnt_next = cnt_reg - 4'd1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            cnt_reg <= 4'd0;
        else
            cnt_reg <= cnt_next;
    end
`else
    assign pready_c = 1'b1;
`endif

    always_comb begin
        state_next = state_reg;
        PREADY     = pready_c;
        PSLVERR    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (setup_c)
                    state_next = ACCESS;
            end
            ACCESS: begin
                PSLVERR = pready_c && err_reg;
                // A master dropping PSEL abandons the transfer without error.
                if (!PSEL || complete_c)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_pulse_next = '0;
        if (commit_c)
            wr_pulse_next[idx_reg] = 1'b1;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            write_reg    <= 1'b0;
            strb_reg     <= '0;
            wdata_reg    <= '0;
            err_reg      <= 1'b0;
            prdata_reg   <= '0;
            wr_pulse_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wr_pulse_reg <= wr_pulse_next;
            if (setup_c) begin
                idx_reg    <= idx_c;
                write_reg  <= PWRITE;
                strb_reg   <= PSTRB;
                wdata_reg  <= PWDATA;
                err_reg    <= err_c;
                prdata_reg <= (!PWRITE && !err_c) ? view[idx_c] : '0;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int r = 0; r < NUM_REGS - 1; r++)
                regs_reg[r] <= '0;
        end else if (commit_c) begin
            for (int r = 0; r < NUM_REGS - 1; r++) begin
                if (idx_reg == IW'(r)) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (strb_reg[b])
                            regs_reg[r][8*b +: 8] <= wdata_reg[8*b +: 8];
                    end
                end
            end
        end
    end

    assign PRDATA   = prdata_reg;
    assign wr_pulse = wr_pulse_reg;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave at default parameters; expectations follow APB_SLV_WAIT_EN if defined.
module tb_apb_reg_slave;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [15:0] PADDR;
    logic [3:0]  PSTRB;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [255:0] reg_q;
    logic [7:0]  wr_pulse;

    int checks = 0;
    int errors = 0;

`ifdef APB_SLV_WAIT_EN
    localparam int EXP_CYCLES = 4;
    localparam int EXP_WAITS  = 2;
`else
    localparam int EXP_CYCLES = 2;
    localparam int EXP_WAITS  = 0;
`endif

    localparam logic [31:0] ID = 32'hA5B0_0001;

    logic [31:0] m [8];

    apb_reg_slave dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSTRB(PSTRB), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .reg_q(reg_q), .wr_pulse(wr_pulse)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pack();
        logic [255:0] p;
        for (int i = 0; i < 8; i++) p[i*32 +: 32] = m[i];
        return p;
    endfunction

    task automatic tick();
        @(posedge PCLK); #1;
    endtask

    // Entered at posedge+1; returns at posedge+1 just after the completion edge.
    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [31:0] rdata,
                        output logic slverr, output int cycles, output int waits);
        logic done;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
        cycles = 1; waits = 0; done = 1'b0; rdata = 'x; slverr = 1'bx;
        tick();
        PENABLE = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge PCLK);
            cycles++;
            if (PREADY) begin
                rdata = PRDATA; slverr = PSLVERR; done = 1'b1;
            end else begin
                waits++;
            end
            tick();
        end
        chk("xfer_done", done, 1'b1);
        PSEL = 1'b0; PENABLE = 1'b0;
        $display("xfer %s addr=%04h wdata=%08h strb=%b -> rdata=%08h slverr=%b cycles=%0d",
                 wr ? "WR" : "RD", addr, data, strb, rdata, slverr, cycles);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        se;
        int          cyc, wt;

        for (int i = 0; i < 7; i++) m[i] = 32'h0;
        m[7] = ID;
        PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0;
        PADDR = '0; PSTRB = '0; PWDATA = '0;

        // 1: reset values and ID read
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_pready", PREADY, 1'b1);
        chk("rst_pslverr", PSLVERR, 1'b0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_reg_q", reg_q, pack());
        chk("rst_wr_pulse", wr_pulse, 8'h0);
        tick();
        PRESETn = 1'b1;
        tick();
        xfer(1'b0, 16'h001C, 32'h0, 4'h0, rd, se, cyc, wt);
        chk("id_rdata", rd, ID);
        chk("id_slverr", se, 1'b0);

        // 2: byte-strobed write and readback
        xfer(1'b1, 16'h0004, 32'hDEAD_BEEF, 4'b0101, rd, se, cyc, wt);
        m[1] = 32'h00AD_00EF;
        chk("wr1_slverr", se, 1'b0);
        chk("wr1_reg_q", reg_q, pack());
        chk("wr1_pulse", wr_pulse, 8'h02);
        tick();
        chk("wr1_pulse_clr", wr_pulse, 8'h00);
        xfer(1'b0, 16'h0004, 32'h0, 4'h0, rd, se, cyc, wt);
        chk("rd1_rdata", rd, 32'h00AD_00EF);
        chk("rd1_slverr", se, 1'b0);

        // 3: error accesses
        xfer(1'b1, 16'h0006, 32'hFFFF_FFFF, 4'hF, rd, se, cyc, wt);
        chk("mis_slverr", se, 1'b1);
        chk("mis_pulse", wr_pulse, 8'h00);
        chk("mis_reg_q", reg_q, pack());
        xfer(1'b1, 16'h0020, 32'hFFFF_FFFF, 4'hF, rd, se, cyc, wt);
        chk("oor_slverr", se, 1'b1);
        chk("oor_pulse", wr_pulse, 8'h00);
        chk("oor_reg_q", reg_q, pack());
        xfer(1'b1, 16'h001C, 32'hFFFF_FFFF, 4'hF, rd, se, cyc, wt);
        chk("ro_slverr", se, 1'b1);
        chk("ro_pulse", wr_pulse, 8'h00);
        chk("ro_reg_q", reg_q, pack());
        xfer(1'b0, 16'h0040, 32'h0, 4'h0, rd, se, cyc, wt);
        chk("oor_rd_rdata", rd, 32'h0);
        chk("oor_rd_slverr", se, 1'b1);
        tick();
        chk("idle_pslverr", PSLVERR, 1'b0);

        // 4: timing and back-to-back writes
        xfer(1'b1, 16'h0000, 32'h1111_1111, 4'hF, rd, se, cyc, wt);
        m[0] = 32'h1111_1111;
        chk("b2b0_cycles", cyc, EXP_CYCLES);
        chk("b2b0_waits", wt, EXP_WAITS);
        chk("b2b0_pulse", wr_pulse, 8'h01);
        xfer(1'b1, 16'h0004, 32'h2222_2222, 4'hF, rd, se, cyc, wt);
        m[1] = 32'h2222_2222;
        chk("b2b1_cycles", cyc, EXP_CYCLES);
        chk("b2b1_pulse", wr_pulse, 8'h02);
        chk("b2b_reg_q", reg_q, pack());

        // 5: master abort during access
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0008;
        PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF;
        tick();
        PSEL = 1'b0;
        @(negedge PCLK);
        chk("abort_pslverr", PSLVERR, 1'b0);
        tick();
        chk("abort_pulse", wr_pulse, 8'h00);
        chk("abort_pready", PREADY, 1'b1);
        tick();
        chk("abort_reg_q", reg_q, pack());
        xfer(1'b0, 16'h0008, 32'h0, 4'h0, rd, se, cyc, wt);
        chk("post_abort_rdata", rd, 32'h0);
        chk("post_abort_cycles", cyc, EXP_CYCLES);

        // PENABLE without a setup phase is ignored
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 16'h0000;
        PWDATA = 32'hAAAA_AAAA; PSTRB = 4'hF;
        @(negedge PCLK);
        chk("noset_pslverr", PSLVERR, 1'b0);
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
        chk("noset_pulse", wr_pulse, 8'h00);
        tick();
        chk("noset_reg_q", reg_q, pack());

        // 6: reset in the middle of a write
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h000C;
        PWDATA = 32'h1234_5678; PSTRB = 4'hF;
        tick();
        PENABLE = 1'b1;
        #2 PRESETn = 1'b0;
        #1;
        for (int i = 0; i < 7; i++) m[i] = 32'h0;
        chk("midrst_pready", PREADY, 1'b1);
        chk("midrst_pulse", wr_pulse, 8'h00);
        chk("midrst_reg_q", reg_q, pack());
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
        tick();
        PRESETn = 1'b1;
        tick();
        xfer(1'b0, 16'h000C, 32'h0, 4'h0, rd, se, cyc, wt);
        chk("postrst_rdata", rd, 32'h0);
        chk("postrst_cycles", cyc, EXP_CYCLES);
        xfer(1'b1, 16'h000C, 32'h1234_5678, 4'hF, rd, se, cyc, wt);
        m[3] = 32'h1234_5678;
        chk("postrst_slverr", se, 1'b0);
        chk("postrst_pulse", wr_pulse, 8'h08);
        chk("postrst_reg_q", reg_q, pack());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
